// File: rtl/exp_add_sched.sv
// Shared exponent adder: round-robin arbitration over NREQ requesters feeding
// a two-stage pipeline (issue register X, result register R) with a
// valid/ready response port. Throughput one op per cycle, latency two cycles.
module exp_add_sched #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy
);

  logic             x_valid_q;
  logic [WIDTH-1:0] x_a_q, x_b_q;
  logic             x_cin_q, x_sub_q;
  logic [1:0]       x_id_q;

  logic             r_valid_q;
  logic [WIDTH-1:0] r_sum_q;
  logic             r_cout_q;
  logic [1:0]       r_id_q;

  logic [1:0]       ptr_q, ptr_d;

  logic             advance, x_can_accept, accept;
  logic             found;
  logic [1:0]       win, idx;
  logic [3:0]       valid_pad;

  logic [WIDTH-1:0] a_sel, b_sel;
  logic             cin_sel, sub_sel;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   add_res;

  // X moves into R whenever R is empty or is being drained this cycle.
  assign advance      = x_valid_q && (!r_valid_q || rsp_ready);
  assign x_can_accept = !x_valid_q || advance;
  assign valid_pad    = 4'(req_valid);

  // Round-robin search starting at ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && valid_pad[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == 2'(NREQ - 1)) ? 2'd0 : idx + 2'd1;
    end
  end

  // Reset gating keeps req_ready low even though X looks empty during reset.
  assign accept = found && x_can_accept && !reset;

  // One-hot grant to the winner only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (win == 2'(i));
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    sub_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 2'(i)) begin
        a_sel   = req_a[i*WIDTH +: WIDTH];
        b_sel   = req_b[i*WIDTH +: WIDTH];
        cin_sel = req_cin[i];
        sub_sel = req_sub[i];
      end
    end
  end

  // Pointer moves past the winner only on an accepted transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
    end
  end

  // Subtract is A + ~B + 1; the carry-in is ignored in that mode.
  always_comb begin
    b_eff   = x_sub_q ? ~x_b_q : x_b_q;
    c_eff   = x_sub_q | x_cin_q;
    add_res = {1'b0, x_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
  end

  // Issue register X and arbitration pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_valid_q <= 1'b0;
      x_a_q     <= '0;
      x_b_q     <= '0;
      x_cin_q   <= 1'b0;
      x_sub_q   <= 1'b0;
      x_id_q    <= 2'd0;
      ptr_q     <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        x_valid_q <= 1'b1;
        x_a_q     <= a_sel;
        x_b_q     <= b_sel;
        x_cin_q   <= cin_sel;
        x_sub_q   <= sub_sel;
        x_id_q    <= win;
      end else if (advance) begin
        x_valid_q <= 1'b0;
      end
    end
  end

  // Result register R; holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_q <= 1'b0;
      r_sum_q   <= '0;
      r_cout_q  <= 1'b0;
      r_id_q    <= 2'd0;
    end else if (advance) begin
      r_valid_q <= 1'b1;
      r_sum_q   <= add_res[WIDTH-1:0];
      r_cout_q  <= add_res[WIDTH];
      r_id_q    <= x_id_q;
    end else if (r_valid_q && rsp_ready) begin
      r_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = r_valid_q;
  assign rsp_id    = r_id_q;
  assign rsp_sum   = r_sum_q;
  assign rsp_cout  = r_cout_q;
  assign busy      = x_valid_q | r_valid_q;

endmodule

// File: tb/tb_exp_add_sched.sv
// Bench for exp_add_sched: directed scenarios plus random traffic, checked
// against a transaction-level reference (grant search, in-order result queue).
module tb_exp_add_sched;
  localparam int N = 3;
  localparam int W = 13;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [N-1:0]     req_cin, req_sub;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_sum;
  logic             rsp_cout;
  logic             busy;

  exp_add_sched #(.NREQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int id;
    int res;
  } op_t;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic         op_cin [N];
  logic         op_sub [N];

  // reference state: occupancy of the two slots, pointer, results in flight
  int  m_xfull, m_rfull, m_ptr;
  op_t exp_q[$];
  logic [N-1:0] last_ready;
  int  accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_res(input int a, input int b, input int cin, input int sub);
    int r;
    if (sub != 0) r = a - b + (1 << W);
    else          r = a + b + cin;
    return r % (1 << (W + 1));
  endfunction

  task automatic m_clear();
    m_xfull = 0;
    m_rfull = 0;
    m_ptr   = 0;
    exp_q.delete();
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i]   = W'($urandom);
      op_b[i]   = W'($urandom);
      op_cin[i] = 1'($urandom);
      op_sub[i] = 1'($urandom);
    end
  endtask

  // One cycle: drive just after the falling edge, check, advance the model,
  // then wait for the next falling edge (rising edge passes in between).
  task automatic cyc(input logic [N-1:0] v, input logic rr);
    int adv, can, winner, idx, k;
    logic [N-1:0] exp_ready;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
      req_cin[i]      = op_cin[i];
      req_sub[i]      = op_sub[i];
    end
    #1;
    adv = (m_xfull != 0 && (m_rfull == 0 || rr)) ? 1 : 0;
    can = (m_xfull == 0 || adv != 0) ? 1 : 0;
    winner = -1;
    if (can != 0) begin
      for (k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (winner < 0 && v[idx]) winner = idx;
      end
    end
    exp_ready = '0;
    if (winner >= 0) exp_ready[winner] = 1'b1;
    last_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rfull));
    chk("busy", 32'(busy), 32'((m_xfull | m_rfull) != 0));
    if (m_rfull != 0 && exp_q.size() > 0) begin
      chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
      chk("rsp_sum", 32'(rsp_sum), 32'(exp_q[0].res % (1 << W)));
      chk("rsp_cout", 32'(rsp_cout), 32'(exp_q[0].res >> W));
      if (rr) void'(exp_q.pop_front());
    end
    if (adv != 0)                m_rfull = 1;
    else if (m_rfull != 0 && rr) m_rfull = 0;
    if (winner >= 0) begin
      op_t o;
      o.id  = winner;
      o.res = ref_res(int'(op_a[winner]), int'(op_b[winner]),
                      int'(op_cin[winner]), int'(op_sub[winner]));
      exp_q.push_back(o);
      m_xfull = 1;
      m_ptr = (winner + 1) % N;
      accepted++;
    end else if (adv != 0) begin
      m_xfull = 0;
    end
    @(negedge clk);
  endtask

  task automatic zero_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_cin[i] = 1'b0; op_sub[i] = 1'b0;
    end
  endtask

  logic [N-1:0] rr_seq [6];

  initial begin
    m_clear();
    accepted  = 0;
    reset     = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_a = '1; req_b = '1; req_cin = '1; req_sub = '0;
    zero_ops();
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rsp_sum", 32'(rsp_sum), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // single add, requester 0
    op_a[0] = 13'h0400; op_b[0] = 13'h0013; op_cin[0] = 1'b1; op_sub[0] = 1'b0;
    cyc(3'b001, 1'b1);
    cyc(3'b000, 1'b1);
    chk("add_valid", 32'(rsp_valid), 32'(1));
    chk("add_id", 32'(rsp_id), 32'(0));
    chk("add_sum", 32'(rsp_sum), 32'h0414);
    chk("add_cout", 32'(rsp_cout), 32'(0));
    cyc(3'b000, 1'b1);

    // subtract with and without borrow, requester 1
    op_a[1] = 13'h0010; op_b[1] = 13'h0020; op_sub[1] = 1'b1; op_cin[1] = 1'b1;
    cyc(3'b010, 1'b1);
    op_a[1] = 13'h0020; op_b[1] = 13'h0010;
    cyc(3'b010, 1'b1);
    chk("sub1_sum", 32'(rsp_sum), 32'h1FF0);
    chk("sub1_cout", 32'(rsp_cout), 32'(0));
    cyc(3'b000, 1'b1);
    chk("sub2_sum", 32'(rsp_sum), 32'h0010);
    chk("sub2_cout", 32'(rsp_cout), 32'(1));
    cyc(3'b000, 1'b1);

    // overflow wrap, requester 2
    op_a[2] = 13'h1FFF; op_b[2] = 13'h0001; op_cin[2] = 1'b0; op_sub[2] = 1'b0;
    cyc(3'b100, 1'b1);
    cyc(3'b000, 1'b1);
    chk("wrap_sum", 32'(rsp_sum), 32'h0000);
    chk("wrap_cout", 32'(rsp_cout), 32'(1));
    cyc(3'b000, 1'b1);

    // round-robin from a fresh reset
    reset = 1'b1;
    m_clear();
    @(negedge clk);
    reset = 1'b0;
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
    rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;
    for (int c = 0; c < 6; c++) begin
      rand_ops();
      cyc(3'b111, 1'b1);
      chk("rr_order", 32'(last_ready), 32'(rr_seq[c]));
    end
    for (int c = 0; c < 3; c++) cyc(3'b000, 1'b1);

    // backpressure from an empty pipeline: two ops fit, then stall
    accepted = 0;
    for (int c = 0; c < 5; c++) begin
      rand_ops();
      cyc(3'b111, 1'b0);
    end
    chk("bp_accepted", 32'(accepted), 32'(2));
    chk("bp_ready_low", 32'(last_ready), 32'(0));
    for (int c = 0; c < 6; c++) begin
      rand_ops();
      cyc(3'b111, 1'b1);
    end
    for (int c = 0; c < 3; c++) cyc(3'b000, 1'b1);
    chk("bp_drained", 32'(exp_q.size()), 32'(0));

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      cyc(N'($urandom), ($urandom_range(3, 0) != 0));
    end
    for (int c = 0; c < 4; c++) cyc(3'b000, 1'b1);
    chk("rand_drained", 32'(busy), 32'(0));

    // reset with X and R both occupied
    cyc(3'b111, 1'b0);
    cyc(3'b111, 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_ready", 32'(req_ready), 32'(0));
    chk("mid_rst_id", 32'(rsp_id), 32'(0));
    chk("mid_rst_sum", 32'(rsp_sum), 32'(0));
    chk("mid_rst_cout", 32'(rsp_cout), 32'(0));
    m_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rand_ops();
    cyc(3'b111, 1'b1);
    chk("post_rst_grant", 32'(last_ready), 32'(3'b001));
    for (int c = 0; c < 4; c++) cyc(3'b000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
